operand_entry: RTL and testbench
================================

# operand_entry

Front-end input stage for the ALU top level. Turns the board's raw slide switches and two active-low push-buttons into clean, registered ALU controls: `IN[7:0]`, `MODE[1:0]` and `OP[1:0]`. It synchronises and debounces the keys and walks the user through a three-step entry sequence. The held outputs drive the ALU datapath and mode display directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles a key level must hold before it is accepted (10 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, default 19: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `CLOCK`, input, 1: single system clock. All state is on its rising edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `SW`, input, 10: raw slide switches, asynchronous to `CLOCK`.
- `KEY_LOAD`, input, 1: raw push-button, active-low (0 = pressed). Advances the entry sequence.
- `KEY_CLR`, input, 1: raw push-button, active-low. Aborts and clears.
- `IN`, output, 8: captured ALU operand byte.
- `MODE`, output, 2: captured ALU mode select.
- `OP`, output, 2: captured ALU operation select.
- `VALID`, output, 1: high while `IN`/`MODE`/`OP` form a complete, committed set.
- `STAGE`, output, 2: current entry state. 0 = S_IN, 1 = S_CTRL, 2 = S_RUN. 3 is never driven.

## Operation
- **Synchronisers:**
  - `SW`, `KEY_LOAD` and `KEY_CLR` each pass through a 2-flop synchroniser.
  - `SW` is not debounced. It is only sampled at capture time.
- **Debounce (one instance per key):**
  - Registers: counter `cnt`, accepted level `db`.
  - If the synced level equals `db`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db` <= synced level and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - A bounce that returns to `db` before the count completes restarts the count and produces no event.
- **Press pulse:**
  - `load_p` / `clr_p` is registered and high for exactly 1 cycle, in the cycle after `db` goes 1→0.
  - A release (`db` 0→1) produces nothing.
  - A held key produces only one pulse.
- **Entry FSM (one-hot or binary, implementer's choice):**
  - S_IN + `load_p`: `IN` <= synced `SW[7:0]`; go to S_CTRL.
  - S_CTRL + `load_p`: `MODE` <= synced `SW[1:0]`, `OP` <= synced `SW[3:2]`; go to S_RUN; `VALID` <= 1.
  - S_RUN + `load_p`: go to S_IN; `VALID` <= 0. `IN`, `MODE` and `OP` hold their old values until overwritten.
  - `clr_p` in any state: go to S_IN; `IN`, `MODE`, `OP` <= 0; `VALID` <= 0.
  - `clr_p` and `load_p` in the same cycle: clear wins and the load is discarded.
  - With no pulse, all registers hold.
  - `SW[9:4]` is unused in S_CTRL. `SW[9:8]` is unused in S_IN.

## Timing
- **Reset values:** `IN` = 0, `MODE` = 0, `OP` = 0, `VALID` = 0, `STAGE` = 0. Synchroniser flops = 1 (keys idle). `db` = 1, `cnt` = 0.
- **Reset assertion:** mid-sequence, `RESET_N` low forces reset values immediately and asynchronously. Release is synchronous to the next `CLOCK` edge.
- **Press latency:** from a raw key falling edge that stays low, the pulse appears after 2 cycles (sync) + `DEBOUNCE_CYCLES` cycles (`db` falls) + 1 cycle (pulse). Outputs update on the following edge. Total from raw edge to output change is `DEBOUNCE_CYCLES`+4 edges, ±1 for metastability resolution.
- **Switch sampling:** the captured `SW` value is the synced value present in the cycle the pulse is high, i.e. the raw `SW` from 2 cycles earlier.
- **`STAGE` and `VALID`:** both are registered and change on the same edge as the captured data. Downstream logic may use `IN`/`MODE`/`OP` combinationally whenever `VALID` = 1.
- **Pulse spacing:** two pulses from the same key are separated by at least `2*DEBOUNCE_CYCLES` cycles, by construction.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `CNT_W` = 3.

1. **Reset:** hold `RESET_N` = 0 with arbitrary `SW`/keys → `IN` = 0x00, `MODE` = 0, `OP` = 0, `VALID` = 0, `STAGE` = 0. Assert `RESET_N` = 0 in S_RUN mid-cycle → outputs return to these values before the next edge.
2. **Full entry:**
   - `SW` = 0x0A5, clean `KEY_LOAD` press → `IN` = 0xA5, `STAGE` = 1, exactly 8 edges after the raw edge.
   - `SW` = 0x00E, press → `MODE` = 2, `OP` = 3, `VALID` = 1, `STAGE` = 2.
   - Press again → `STAGE` = 0, `VALID` = 0, `IN` still 0xA5.
3. **Bounce rejection:** `KEY_LOAD` toggles 0,1,0,1,0 at 1–3 cycle intervals, then is held low → exactly one capture, no earlier `STAGE` change. A 3-cycle glitch followed by release → no capture at all.
4. **Hold and release:** `KEY_LOAD` held low for 50 cycles, then released → a single `STAGE` advance. The release causes no change.
5. **Clear priority:** in S_CTRL with `IN` = 0x3C, press `KEY_CLR` and `KEY_LOAD` aligned to the same cycle → `STAGE` = 0, `IN` = 0x00, `MODE` = 0, `OP` = 0, `VALID` = 0.
6. **Sampling point:** `SW` changes from 0x011 to 0x0FF exactly 1 cycle before the pulse cycle → captured `IN` = 0x11 (2-cycle synchroniser lag). A change 3 cycles before the pulse → `IN` = 0xFF.

Source files
------------

// File: rtl/operand_entry_if.sv
// Handshake bundle between the board I/O (switches, keys) and the operand entry stage.
// The master drives the raw board inputs; the slave returns the held ALU controls.
interface operand_entry_if;
    logic [9:0] sw;
    logic       key_load;
    logic       key_clr;
    logic [7:0] in;
    logic [1:0] mode;
    logic [1:0] op;
    logic       valid;
    logic [1:0] stage;

    modport master (
        output sw, key_load, key_clr,
        input  in, mode, op, valid, stage
    );

    modport slave (
        input  sw, key_load, key_clr,
        output in, mode, op, valid, stage
    );
endinterface

// File: rtl/operand_entry.sv
// ALU front end: synchronises switches and keys, debounces the keys and walks a
// three-step entry sequence (operand byte, then mode/op, then run) into held registers.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic           clock,
    input  logic           reset_n,
    operand_entry_if.slave bus
);

    typedef enum logic [1:0] {
        S_IN   = 2'd0,
        S_CTRL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Key vectors are indexed [0] = load, [1] = clear.
    logic [9:0]       sw_s1, sw_s2;
    logic [1:0]       key_s1, key_s2;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       db, db_d, press;
    logic             load_p, clr_p;

    state_e           state_q, state_d;
    logic [7:0]       in_q, in_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       op_q, op_d;
    logic             valid_q, valid_d;
    logic             unused_sw;

    // Keys reset to their released (high) level so no press is seen leaving reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= bus.sw;
            sw_s2  <= sw_s1;
            key_s1 <= {bus.key_clr, bus.key_load};
            key_s2 <= key_s1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
            db    <= '1;
            db_d  <= '1;
            press <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] == db[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    db[k]  <= key_s2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
            db_d  <= db;
            press <= db_d & ~db;
        end
    end

    assign load_p = press[0];
    assign clr_p  = press[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IN;
            in_q    <= '0;
            mode_q  <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    // Clear has priority over load; a simultaneous load is dropped.
    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        mode_d  = mode_q;
        op_d    = op_q;
        valid_d = valid_q;
        if (clr_p) begin
            state_d = S_IN;
            in_d    = '0;
            mode_d  = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else if (load_p) begin
            case (state_q)
                S_IN: begin
                    in_d    = sw_s2[7:0];
                    state_d = S_CTRL;
                end
                S_CTRL: begin
                    mode_d  = sw_s2[1:0];
                    op_d    = sw_s2[3:2];
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    valid_d = 1'b0;
                    state_d = S_IN;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_IN;
                end
            endcase
        end
    end

    assign unused_sw = ^sw_s2[9:8];

    assign bus.in    = in_q;
    assign bus.mode  = mode_q;
    assign bus.op    = op_q;
    assign bus.valid = valid_q;
    assign bus.stage = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: stimulus queues expected output snapshots and
// the edge they must appear on; a monitor pops and compares on every output change.
module tb_operand_entry;

    typedef struct {
        string      name;
        logic [14:0] snap;
        int         cyc;
    } exp_t;

    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    exp_t exp_q[$];

    operand_entry_if bus ();

    operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Snapshot layout: {stage, valid, in, mode, op}.
    function automatic logic [14:0] s(input int stage, input int valid, input int in,
                                      input int mode, input int op);
        logic [1:0] st, md, o;
        logic [7:0] iv;
        logic       v;
        st = stage[1:0];
        v  = valid[0];
        iv = in[7:0];
        md = mode[1:0];
        o  = op[1:0];
        return {st, v, iv, md, o};
    endfunction

    function automatic logic [14:0] snap_now();
        return {bus.stage, bus.valid, bus.in, bus.mode, bus.op};
    endfunction

    task automatic expect_at(input string name, input logic [14:0] snap, input int at);
        exp_t e;
        e.name = name;
        e.snap = snap;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Press one or both keys cleanly, hold, release and let the release settle.
    task automatic press(input string name, input logic [9:0] swv, input bit ld, input bit cl,
                         input logic [14:0] snap, input int hold);
        @(negedge clock);
        bus.sw = swv;
        if (ld) bus.key_load = 1'b0;
        if (cl) bus.key_clr = 1'b0;
        expect_at(name, snap, cyc + 8);
        repeat (hold) @(negedge clock);
        bus.key_load = 1'b1;
        bus.key_clr  = 1'b1;
        repeat (16) @(negedge clock);
    endtask

    // Capture with SW changing n_before edges after the raw key edge.
    task automatic sample_test(input string name, input int change_after,
                               input logic [14:0] snap);
        @(negedge clock);
        bus.sw       = 10'h011;
        bus.key_load = 1'b0;
        expect_at(name, snap, cyc + 8);
        repeat (change_after) @(negedge clock);
        bus.sw = 10'h0FF;
        repeat (12 - change_after) @(negedge clock);
        bus.key_load = 1'b1;
        repeat (16) @(negedge clock);
    endtask

    always @(negedge clock) begin
        logic [14:0] now;
        logic [14:0] prev;
        exp_t        e;
        now = snap_now();
        if (mon_en && now !== prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", now, prev);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_outputs"}, now, e.snap);
                if (e.cyc >= 0) check({e.name, "_edge"}, cyc, e.cyc);
            end
        end
        prev = now;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        bus.sw       = 10'($urandom);
        bus.key_load = 1'b0;
        bus.key_clr  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_in", bus.in, 8'h00);
        check("reset_mode", bus.mode, 2'd0);
        check("reset_op", bus.op, 2'd0);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_stage", bus.stage, 2'd0);
        bus.key_load = 1'b1;
        bus.key_clr  = 1'b1;
        bus.sw       = 10'h000;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;

        // Full three-step entry.
        press("entry_in", 10'h0A5, 1, 0, s(1, 0, 8'hA5, 0, 0), 12);
        press("entry_ctrl", 10'h00E, 1, 0, s(2, 1, 8'hA5, 2, 3), 12);
        press("entry_run", 10'h3FF, 1, 0, s(0, 0, 8'hA5, 2, 3), 12);

        // Bouncing press: 0,1,1,0,0,0,1 then held low.
        @(negedge clock);
        bus.sw       = 10'h05A;
        bus.key_load = 1'b0;
        @(negedge clock);
        bus.key_load = 1'b1;
        repeat (2) @(negedge clock);
        bus.key_load = 1'b0;
        repeat (3) @(negedge clock);
        bus.key_load = 1'b1;
        @(negedge clock);
        bus.key_load = 1'b0;
        expect_at("bounce", s(1, 0, 8'h5A, 2, 3), cyc + 8);
        repeat (12) @(negedge clock);
        bus.key_load = 1'b1;
        repeat (16) @(negedge clock);

        // Short glitch: must not register.
        @(negedge clock);
        bus.key_load = 1'b0;
        repeat (3) @(negedge clock);
        bus.key_load = 1'b1;
        repeat (16) @(negedge clock);

        // Long hold: single advance, release silent.
        press("hold", 10'h009, 1, 0, s(2, 1, 8'h5A, 1, 2), 50);

        // Clear beats a same-cycle load in S_CTRL.
        press("to_in", 10'h000, 1, 0, s(0, 0, 8'h5A, 1, 2), 12);
        press("to_ctrl", 10'h03C, 1, 0, s(1, 0, 8'h3C, 1, 2), 12);
        press("clr_priority", 10'h3FF, 1, 1, s(0, 0, 8'h00, 0, 0), 12);

        // Sampling point relative to the pulse cycle.
        sample_test("sample_late", 6, s(1, 0, 8'h11, 0, 0));
        press("clr_only", 10'h000, 0, 1, s(0, 0, 8'h00, 0, 0), 12);
        sample_test("sample_early", 4, s(1, 0, 8'hFF, 0, 0));
        press("to_run", 10'h000, 1, 0, s(2, 1, 8'hFF, 0, 0), 12);

        // Asynchronous reset in S_RUN, observed before the next edge.
        @(posedge clock);
        #2;
        expect_at("async_reset", s(0, 0, 8'h00, 0, 0), -1);
        reset_n = 1'b0;
        #1;
        check("areset_in", bus.in, 8'h00);
        check("areset_mode", bus.mode, 2'd0);
        check("areset_op", bus.op, 2'd0);
        check("areset_valid", bus.valid, 1'b0);
        check("areset_stage", bus.stage, 2'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
